// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the core's load/store controller. Accepts one
// data-memory request at a time over a valid/ready handshake, waits LATENCY
// cycles, then commits the access to a word-organised array: stores update
// only the enabled byte lanes, and loads return the addressed byte/half/word
// shifted down to bit 0 with the upper bits zero. Sign extension is left to
// the core-side controller.
//
// Optional feature (compile-time macro DMEM_MISALIGN_TRAP_EN):
//   defined   : a misaligned half/word access returns rsp_err=1, rdata=0, and
//               a misaligned store is suppressed.
//   undefined : rsp_err is always 0 and misaligned addresses are force-aligned.
//
// Parameters:
//   SIZE     byte-address width; array holds 2^(SIZE-2) 32-bit words
//   LATENCY  wait cycles between accept and commit (0..15)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_ctrl   000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
//   req_addr   byte address
//   req_wdata  store data, right-justified
//   rsp_valid  response present
//   rsp_ready  core consumes response
//   rsp_rdata  load data aligned to bit 0; 0 for stores
//   rsp_err    misaligned-access flag
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int SIZE    = 12,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_ctrl,
  input  logic [SIZE-1:0] req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int DEPTH = 2 ** (SIZE - 2);
  localparam logic [3:0] LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LW  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b011;
  localparam logic [2:0] C_LHU = 3'b100;
  localparam logic [2:0] C_SB  = 3'b101;
  localparam logic [2:0] C_SH  = 3'b110;
  localparam logic [2:0] C_SW  = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [SIZE-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [DEPTH];

  // Access-path signals
  logic              accept;
  logic              commit;
  logic [2:0]        cur_ctrl;
  logic [SIZE-1:0]   cur_addr;
  logic [31:0]       cur_wdata;
  logic              is_half;
  logic              is_word;
  logic              is_store;
  logic [SIZE-1:0]   al_addr;
  logic [SIZE-3:0]   idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [31:0]       fmt_rdata;
  logic              fmt_err;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic              we;

  always_comb begin
    accept = (state_q == IDLE) && req_valid && req_ready_q;

    // With LATENCY=0 the commit happens on the accept edge itself, so the
    // access path must look at the live request rather than the latched copy.
    cur_ctrl  = (state_q == IDLE) ? req_ctrl  : ctrl_q;
    cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    commit = ((state_q == WAIT) && (cnt_q == 4'd0)) || (accept && (LATENCY == 0));

    is_half  = (cur_ctrl == C_LH) || (cur_ctrl == C_LHU) || (cur_ctrl == C_SH);
    is_word  = (cur_ctrl == C_LW) || (cur_ctrl == C_SW);
    is_store = (cur_ctrl == C_SB) || (cur_ctrl == C_SH) || (cur_ctrl == C_SW);

    // Force alignment; a no-op for aligned accesses, so the trap build can
    // share the same address path.
    al_addr = cur_addr;
    if (is_half) al_addr[0]   = 1'b0;
    if (is_word) al_addr[1:0] = 2'b00;

    idx     = al_addr[SIZE-1:2];
    lane    = al_addr[1:0];
    rd_word = mem[idx];

    // Store lane enables and data replicated across lanes so each enabled
    // byte picks up the correct source byte.
    be   = 4'b0000;
    wrep = cur_wdata;
    case (cur_ctrl)
      C_SB: begin
        be   = 4'b0001 << lane;
        wrep = {4{cur_wdata[7:0]}};
      end
      C_SH: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{cur_wdata[15:0]}};
      end
      C_SW: begin
        be   = 4'b1111;
        wrep = cur_wdata;
      end
      default: ;
    endcase

    case (cur_ctrl)
      C_LB, C_LBU: fmt_rdata = {24'b0, rd_word[{lane, 3'b000} +: 8]};
      C_LH, C_LHU: fmt_rdata = {16'b0, rd_word[{lane[1], 4'b0000} +: 16]};
      C_LW:        fmt_rdata = rd_word;
      default:     fmt_rdata = 32'b0;
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    fmt_err = (is_half && cur_addr[0]) || (is_word && (cur_addr[1:0] != 2'b00));
    if (fmt_err) fmt_rdata = 32'b0;
    we = commit && is_store && !fmt_err;
`else
    fmt_err = 1'b0;
    we      = commit && is_store;
`endif
  end

  // Next-state / output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          ctrl_d      = req_ctrl;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (LATENCY == 0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fmt_rdata;
            rsp_err_d   = fmt_err;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = fmt_rdata;
          rsp_err_d   = fmt_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ctrl_q      <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is deliberately not reset; a reset in RESP leaves a committed
  // store in place because the write already happened on the entry edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int SIZE = 12;
  localparam int LAT  = 1;

  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LW  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b011;
  localparam logic [2:0] C_LHU = 3'b100;
  localparam logic [2:0] C_SB  = 3'b101;
  localparam logic [2:0] C_SH  = 3'b110;
  localparam logic [2:0] C_SW  = 3'b111;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_ctrl = 3'b000;
  logic [SIZE-1:0] req_addr = '0;
  logic [31:0]     req_wdata = 32'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];

  dmem_responder #(.SIZE(SIZE), .LATENCY(LAT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full transaction: push expectation, accept, measure latency, optional
  // back-pressure (with a competing request that must be ignored), compare.
  task automatic txn(input string tag, input logic [2:0] ctrl, input logic [SIZE-1:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e,
                     input int stall);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk1({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    sb.push_back('{exp_d, exp_e, tag});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk1({tag, "_busy"}, req_ready, 1'b0);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(LAT + 1));
    for (int i = 0; i < stall; i++) begin
      // Competing byte store that must not be accepted while busy.
      req_valid = 1'b1;
      req_ctrl  = C_SB;
      req_addr  = 12'h013;
      req_wdata = 32'h0000_0000;
      chk1({tag, "_hold_v"}, rsp_valid, 1'b1);
      chk({tag, "_hold_d"}, rsp_rdata, sb[0].rdata);
      chk1({tag, "_hold_rdy"}, req_ready, 1'b0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (sb.size() == 0) begin
      chk1({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
      chk1({e.tag, "_err"}, rsp_err, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1({tag, "_vdone"}, rsp_valid, 1'b0);
    chk1({tag, "_rdone"}, req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_err", rsp_err, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rel_ready_pre", req_ready, 1'b0);
    @(negedge clk);
    chk1("rel_ready_post", req_ready, 1'b1);
    chk1("rel_valid", rsp_valid, 1'b0);

    // Word store and lane-aligned loads
    txn("sw10",  C_SW,  12'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    txn("lb11",  C_LB,  12'h011, 32'h0, 32'h0000_00BE, 1'b0, 0);
    txn("lh12",  C_LH,  12'h012, 32'h0, 32'h0000_DEAD, 1'b0, 0);
    txn("lw10",  C_LW,  12'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    txn("lbu10", C_LBU, 12'h010, 32'h0, 32'h0000_00EF, 1'b0, 0);
    txn("lhu10", C_LHU, 12'h010, 32'h0, 32'h0000_BEEF, 1'b0, 0);

    // Partial stores: upper wdata bits must be ignored
    txn("sb13",  C_SB,  12'h013, 32'hAAAA_AA55, 32'h0, 1'b0, 0);
    txn("lw10b", C_LW,  12'h010, 32'h0, 32'h55AD_BEEF, 1'b0, 0);
    txn("sh10",  C_SH,  12'h010, 32'hFFFF_1234, 32'h0, 1'b0, 0);
    txn("lw10c", C_LW,  12'h010, 32'h0, 32'h55AD_1234, 1'b0, 0);

    // Back-pressure: 5 cycles with rsp_ready low and a competing request
    txn("stall", C_LW,  12'h010, 32'h0, 32'h55AD_1234, 1'b0, 5);
    txn("lw10d", C_LW,  12'h010, 32'h0, 32'h55AD_1234, 1'b0, 0);

    // Misaligned accesses
    txn("sw20",  C_SW,  12'h020, 32'h1122_3344, 32'h0, 1'b0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("sh21",  C_SH,  12'h021, 32'h0000_BEEF, 32'h0, 1'b1, 0);
    txn("lw20",  C_LW,  12'h020, 32'h0, 32'h1122_3344, 1'b0, 0);
    txn("lw22",  C_LW,  12'h022, 32'h0, 32'h0, 1'b1, 0);
    txn("lh23",  C_LH,  12'h023, 32'h0, 32'h0, 1'b1, 0);
`else
    txn("sh21",  C_SH,  12'h021, 32'h0000_BEEF, 32'h0, 1'b0, 0);
    txn("lw20",  C_LW,  12'h020, 32'h0, 32'h1122_BEEF, 1'b0, 0);
    txn("lw22",  C_LW,  12'h022, 32'h0, 32'h1122_BEEF, 1'b0, 0);
    txn("lh23",  C_LH,  12'h023, 32'h0, 32'h0000_1122, 1'b0, 0);
`endif

    // Reset while waiting drops the store
    txn("sw30",  C_SW,  12'h030, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
    req_valid = 1'b1;
    req_ctrl  = C_SW;
    req_addr  = 12'h030;
    req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("midrst_valid", rsp_valid, 1'b0);
    chk1("midrst_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("postrst_ready", req_ready, 1'b1);
    txn("lw30",  C_LW,  12'h030, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
